// File: rtl/cla_adder_pipe.sv
// Pipelined hierarchical carry-lookahead adder/subtractor with a valid/ready handshake.
// Define CLA_ADDER_PIPE_FLAGS_EN to compute and pipeline the ovf and zero status flags.
module cla_adder_pipe #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             co,
   output logic             ovf,
   output logic             zero
);

   // Number of 4-ary lookahead levels needed to cover WIDTH bits.
   function automatic int unsigned calc_nl(input int unsigned w);
      int unsigned nl;
      nl = 0;
      for (int unsigned k = 4; k >= 1; k--) begin
         if ((32'd1 << (2 * k)) >= w) nl = k;
      end
      return nl;
   endfunction

   localparam int unsigned NL = calc_nl(WIDTH);
   localparam int unsigned NP = NL + 2;

   typedef logic [NL:0][WIDTH-1:0] tree_t;

   typedef struct packed {
      tree_t            tp;
      tree_t            tg;
      logic             cin;
      logic [WIDTH-1:0] sum;
      logic             co;
`ifdef CLA_ADDER_PIPE_FLAGS_EN
      logic             ovf;
      logic             zero;
`endif
   } pay_t;

   function automatic int unsigned nodes(input int unsigned k);
      return (WIDTH + (32'd1 << (2 * k)) - 1) >> (2 * k);
   endfunction

   function automatic pay_t prep(input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i,
                                 input logic ci_i, input logic sub_i);
      pay_t             r;
      logic [WIDTH-1:0] beff;
      r       = '0;
      beff    = b_i ^ {WIDTH{sub_i}};
      r.tp[0] = a_i ^ beff;
      r.tg[0] = a_i & beff;
      r.cin   = ci_i | sub_i;
      return r;
   endfunction

   // Group P/G for level k; children beyond the operand width act as pure propagate.
   function automatic pay_t up_level(input pay_t x, input int unsigned k);
      pay_t        r;
      logic [3:0]  cp, cg;
      int unsigned idx;
      r = x;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (i < nodes(k)) begin
            for (int unsigned m = 0; m < 4; m++) begin
               idx = 4 * i + m;
               if (idx < nodes(k - 1)) begin
                  cp[m] = x.tp[k-1][idx];
                  cg[m] = x.tg[k-1][idx];
               end else begin
                  cp[m] = 1'b1;
                  cg[m] = 1'b0;
               end
            end
            r.tp[k][i] = &cp;
            r.tg[k][i] = cg[3] | (cp[3] & cg[2]) | (cp[3] & cp[2] & cg[1])
                       | (cp[3] & cp[2] & cp[1] & cg[0]);
         end
      end
      return r;
   endfunction

   // Carries flow from the root back down to bit level, then form the sum and flags.
   function automatic pay_t down_sweep(input pay_t x);
      pay_t        r;
      tree_t       cn;
      logic [3:0]  cp, cg, cc;
      logic        c;
      int unsigned idx;
      r         = x;
      cn        = '0;
      cn[NL][0] = x.cin;
      for (int unsigned k = NL; k >= 1; k--) begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            if (i < nodes(k)) begin
               c = cn[k][i];
               for (int unsigned m = 0; m < 4; m++) begin
                  idx = 4 * i + m;
                  if (idx < nodes(k - 1)) begin
                     cp[m] = x.tp[k-1][idx];
                     cg[m] = x.tg[k-1][idx];
                  end else begin
                     cp[m] = 1'b1;
                     cg[m] = 1'b0;
                  end
               end
               cc[0] = c;
               cc[1] = cg[0] | (cp[0] & c);
               cc[2] = cg[1] | (cp[1] & cg[0]) | (cp[1] & cp[0] & c);
               cc[3] = cg[2] | (cp[2] & cg[1]) | (cp[2] & cp[1] & cg[0]) | (cp[2] & cp[1] & cp[0] & c);
               for (int unsigned m = 0; m < 4; m++) begin
                  idx = 4 * i + m;
                  if (idx < nodes(k - 1)) cn[k-1][idx] = cc[m];
               end
            end
         end
      end
      r.sum = x.tp[0] ^ cn[0];
      r.co  = x.tg[NL][0] | (x.tp[NL][0] & x.cin);
`ifdef CLA_ADDER_PIPE_FLAGS_EN
      r.ovf  = cn[0][WIDTH-1] ^ r.co;
      r.zero = ~|r.sum;
`endif
      return r;
   endfunction

   // Phase j (1..NL up-levels, then the down-sweep) lands in front of register j*STAGES/NP.
   function automatic pay_t stage_fn(input pay_t x, input int unsigned s);
      pay_t r;
      r = x;
      for (int unsigned j = 1; j < NP; j++) begin
         if ((j * STAGES) / NP == s) begin
            if (j <= NL) r = up_level(r, j);
            else         r = down_sweep(r);
         end
      end
      return r;
   endfunction

   pay_t              pipe_q [STAGES];
   pay_t              pipe_d [STAGES];
   logic [STAGES-1:0] vld_q, vld_d;
   logic              adv;

   always_comb begin
      adv       = ~vld_q[STAGES-1] | out_ready;
      pipe_d[0] = stage_fn(prep(a, b, ci, sub), 0);
      vld_d[0]  = in_valid;
      for (int unsigned s = 1; s < STAGES; s++) begin
         pipe_d[s] = stage_fn(pipe_q[s-1], s);
         vld_d[s]  = vld_q[s-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         for (int unsigned s = 0; s < STAGES; s++) pipe_q[s] <= '0;
      end else if (adv) begin
         vld_q  <= vld_d;
         pipe_q <= pipe_d;
      end
   end

   assign in_ready  = adv;
   assign out_valid = vld_q[STAGES-1];
   assign sum       = pipe_q[STAGES-1].sum;
   assign co        = pipe_q[STAGES-1].co;
`ifdef CLA_ADDER_PIPE_FLAGS_EN
   assign ovf       = pipe_q[STAGES-1].ovf;
   assign zero      = pipe_q[STAGES-1].zero;
`else
   assign ovf       = 1'b0;
   assign zero      = 1'b0;
`endif

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Self-checking bench for cla_adder_pipe: directed cases, handshake scenarios and a
// randomized multi-configuration sweep against an arithmetic reference model.
module tb_cla_adder_pipe;

`ifdef CLA_ADDER_PIPE_FLAGS_EN
   localparam bit FLAGS = 1'b1;
`else
   localparam bit FLAGS = 1'b0;
`endif
   localparam int unsigned NSW = 12;

   typedef struct packed {
      logic [63:0] sum;
      logic        co;
      logic        ovf;
      logic        zero;
   } res_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, out_ready = 1'b0;
   logic [31:0] a = '0, b = '0;
   logic        ci = 1'b0, sub = 1'b0;
   logic        in_ready, out_valid, co, ovf, zero;
   logic [31:0] sum;

   logic [63:0]    sw_a = '0, sw_b = '0;
   logic           sw_ci = 1'b0, sw_sub = 1'b0, sw_valid = 1'b0, sw_ready = 1'b1;
   logic [63:0]    sw_sum [NSW];
   logic [NSW-1:0] sw_co, sw_ovf, sw_zero, sw_ov, sw_ir;

   int   n_vec = 0;
   int   n_bad = 0;
   res_t exp_q[$];

   always #5 clk = ~clk;

   cla_adder_pipe #(.WIDTH(32), .STAGES(2)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .ci(ci), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .co(co), .ovf(ovf), .zero(zero)
   );

   for (genvar gi = 0; gi < NSW; gi++) begin : g_sw
      localparam int unsigned GW = (gi / 4 == 0) ? 4 : ((gi / 4 == 1) ? 32 : 64);
      localparam int unsigned GS = gi % 4 + 1;
      logic [GW-1:0] s_w;
      cla_adder_pipe #(.WIDTH(GW), .STAGES(GS)) u_sw (
         .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ir[gi]),
         .a(sw_a[GW-1:0]), .b(sw_b[GW-1:0]), .ci(sw_ci), .sub(sw_sub),
         .out_valid(sw_ov[gi]), .out_ready(sw_ready),
         .sum(s_w), .co(sw_co[gi]), .ovf(sw_ovf[gi]), .zero(sw_zero[gi])
      );
      assign sw_sum[gi] = 64'(s_w);
   end

   function automatic int unsigned sw_width(input int unsigned i);
      return (i / 4 == 0) ? 4 : ((i / 4 == 1) ? 32 : 64);
   endfunction

   // Plain arithmetic: two's-complement add, signed overflow from operand/result signs.
   function automatic res_t ref_add(input logic [63:0] a_i, input logic [63:0] b_i,
                                    input logic ci_i, input logic sub_i, input int unsigned w);
      logic [63:0] mask, am, bm;
      logic [64:0] full;
      res_t        r;
      mask   = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      am     = a_i & mask;
      bm     = (sub_i ? ~b_i : b_i) & mask;
      full   = {1'b0, am} + {1'b0, bm} + {64'd0, (ci_i | sub_i)};
      r.sum  = full[63:0] & mask;
      r.co   = full[w];
      r.ovf  = FLAGS && (am[w-1] == bm[w-1]) && (r.sum[w-1] != am[w-1]);
      r.zero = FLAGS && (r.sum == 64'd0);
      return r;
   endfunction

   function automatic logic [63:0] pick();
      case ($urandom % 7)
         0: return '0;
         1: return '1;
         2: return 64'd1;
         3: return 64'h7FFF_FFFF_FFFF_FFF7;
         4: return 64'h0000_0000_7FFF_FFFF;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   function automatic logic [31:0] pick32();
      return 32'(pick());
   endfunction

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      n_vec++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      n_vec++; if ({sum, co, ovf, zero} !== 35'd0) begin
         n_bad++; $display("FAIL reset_outputs: got sum=%h co=%b ovf=%b zero=%b expected all 0", sum, co, ovf, zero);
      end
      rst = 1'b0;
   endtask

   task automatic test_vector(input string nm, input logic [31:0] av, input logic [31:0] bv,
                              input logic civ, input logic subv, input logic [31:0] es,
                              input logic eco, input logic eovf, input logic ezero);
      in_valid = 1'b1; a = av; b = bv; ci = civ; sub = subv; out_ready = 1'b1;
      #1;
      n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL %s_in_ready: got %b expected 1", nm, in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL %s_latency_early: got out_valid=%b expected 0", nm, out_valid); end
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b1 || sum !== es || co !== eco || ovf !== (FLAGS & eovf) || zero !== (FLAGS & ezero)) begin
         n_bad++;
         $display("FAIL %s: got v=%b sum=%h co=%b ovf=%b zero=%b expected v=1 sum=%h co=%b ovf=%b zero=%b",
                  nm, out_valid, sum, co, ovf, zero, es, eco, FLAGS & eovf, FLAGS & ezero);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      res_t        e;
      int unsigned got, first_t, last_t;
      got = 0; first_t = 0; last_t = 0;
      exp_q.delete();
      out_ready = 1'b1;
      for (int unsigned t = 0; t < 12; t++) begin
         in_valid = (t < 8); a = pick32(); b = pick32(); ci = 1'($urandom); sub = 1'($urandom);
         #1;
         n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready t=%0d: got %b expected 1", t, in_ready); end
         if (out_valid === 1'b1) begin
            if (got == 0) first_t = t;
            last_t = t;
            got++;
            n_vec++;
            if (exp_q.size() == 0) begin
               n_bad++; $display("FAIL b2b_extra: got sum=%h expected no result", sum);
            end else begin
               e = exp_q.pop_front();
               if (sum !== e.sum[31:0] || co !== e.co || ovf !== e.ovf || zero !== e.zero) begin
                  n_bad++; $display("FAIL b2b_data: got %h/%b%b%b expected %h/%b%b%b", sum, co, ovf, zero, e.sum[31:0], e.co, e.ovf, e.zero);
               end
            end
         end
         if (in_valid && in_ready) exp_q.push_back(ref_add({32'd0, a}, {32'd0, b}, ci, sub, 32));
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_vec++;
      if (got != 8 || last_t - first_t != 7) begin
         n_bad++; $display("FAIL b2b_stream: got %0d results over %0d cycles expected 8 over 8", got, last_t - first_t + 1);
      end
   endtask

   task automatic test_stall();
      res_t        e;
      int unsigned got;
      exp_q.delete();
      got = 0;
      out_ready = 1'b0;
      for (int unsigned k = 0; k < 2; k++) begin
         in_valid = 1'b1; a = pick32(); b = pick32(); ci = 1'($urandom); sub = 1'($urandom);
         #1;
         n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_fill_ready: got %b expected 1", in_ready); end
         exp_q.push_back(ref_add({32'd0, a}, {32'd0, b}, ci, sub, 32));
         @(posedge clk); #1;
      end
      a = 32'h1234_5678; b = 32'h0F0F_0F0F; ci = 1'b1; sub = 1'b0;
      for (int unsigned k = 0; k < 5; k++) begin
         #1;
         n_vec++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || sum !== exp_q[0].sum[31:0] || co !== exp_q[0].co) begin
            n_bad++;
            $display("FAIL stall_hold cyc=%0d: got ready=%b v=%b sum=%h co=%b expected ready=0 v=1 sum=%h co=%b",
                     k, in_ready, out_valid, sum, co, exp_q[0].sum[31:0], exp_q[0].co);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      exp_q.push_back(ref_add({32'd0, a}, {32'd0, b}, ci, sub, 32));
      for (int unsigned k = 0; k < 6; k++) begin
         #1;
         if (k == 0) begin
            n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_release_ready: got %b expected 1", in_ready); end
         end
         if (out_valid === 1'b1) begin
            got++;
            n_vec++;
            if (exp_q.size() == 0) begin
               n_bad++; $display("FAIL stall_dup: got sum=%h expected no result", sum);
            end else begin
               e = exp_q.pop_front();
               if (sum !== e.sum[31:0] || co !== e.co || ovf !== e.ovf || zero !== e.zero) begin
                  n_bad++; $display("FAIL stall_drain: got %h/%b expected %h/%b", sum, co, e.sum[31:0], e.co);
               end
            end
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
      n_vec++;
      if (got != 3 || exp_q.size() != 0) begin
         n_bad++; $display("FAIL stall_count: got %0d results (%0d left) expected 3 (0 left)", got, exp_q.size());
      end
   endtask

   task automatic test_reset_flight();
      out_ready = 1'b1;
      for (int unsigned k = 0; k < 2; k++) begin
         in_valid = 1'b1; a = 32'd1234 + k; b = 32'd1; ci = 1'b0; sub = 1'b0;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rstfl_inflight: got v=%b expected 1", out_valid); end
      rst = 1'b1;
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || {sum, co, ovf, zero} !== 35'd0) begin
         n_bad++;
         $display("FAIL rstfl_async: got v=%b ready=%b sum=%h co=%b ovf=%b zero=%b expected v=0 ready=1 rest 0",
                  out_valid, in_ready, sum, co, ovf, zero);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int unsigned k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstfl_ghost cyc=%0d: got v=%b sum=%h expected v=0", k, out_valid, sum); end
      end
   endtask

   task automatic test_random_handshake();
      res_t        e;
      logic [31:0] h_sum;
      logic        h_co, hold_chk;
      exp_q.delete();
      hold_chk = 1'b0; h_sum = '0; h_co = 1'b0;
      for (int unsigned t = 0; t < 300; t++) begin
         if (hold_chk) begin
            n_vec++;
            if (out_valid !== 1'b1 || sum !== h_sum || co !== h_co) begin
               n_bad++; $display("FAIL rnd_stable t=%0d: got v=%b sum=%h co=%b expected v=1 sum=%h co=%b", t, out_valid, sum, co, h_sum, h_co);
            end
         end
         out_ready = ($urandom % 4) != 0; in_valid = ($urandom % 3) != 0;
         a = pick32(); b = pick32(); ci = 1'($urandom); sub = 1'($urandom);
         #1;
         n_vec++;
         if (in_ready !== (!out_valid || out_ready)) begin
            n_bad++; $display("FAIL rnd_in_ready t=%0d: got %b expected %b", t, in_ready, !out_valid || out_ready);
         end
         hold_chk = out_valid && !out_ready; h_sum = sum; h_co = co;
         if (out_valid && out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_bad++; $display("FAIL rnd_extra t=%0d: got sum=%h expected no result", t, sum);
            end else begin
               e = exp_q.pop_front();
               if (sum !== e.sum[31:0] || co !== e.co || ovf !== e.ovf || zero !== e.zero) begin
                  n_bad++; $display("FAIL rnd_data t=%0d: got %h/%b%b%b expected %h/%b%b%b", t, sum, co, ovf, zero, e.sum[31:0], e.co, e.ovf, e.zero);
               end
            end
         end
         if (in_valid && in_ready) exp_q.push_back(ref_add({32'd0, a}, {32'd0, b}, ci, sub, 32));
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int unsigned k = 0; k < 6; k++) begin
         #1;
         if (out_valid === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_bad++; $display("FAIL rnd_drain_extra: got sum=%h expected no result", sum);
            end else begin
               e = exp_q.pop_front();
               if (sum !== e.sum[31:0] || co !== e.co) begin
                  n_bad++; $display("FAIL rnd_drain: got %h/%b expected %h/%b", sum, co, e.sum[31:0], e.co);
               end
            end
         end
         @(posedge clk); #1;
      end
      n_vec++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rnd_lost: got %0d undelivered expected 0", exp_q.size()); end
   endtask

   task automatic test_sweep();
      logic [63:0] ha [200];
      logic [63:0] hb [200];
      logic        hv [200];
      logic        hci [200];
      logic        hsub [200];
      res_t        e;
      int          d;
      logic        ev;
      sw_ready = 1'b1;
      for (int t = 0; t < 200; t++) begin
         hv[t] = ($urandom % 4) != 0; ha[t] = pick(); hb[t] = pick();
         hci[t] = 1'($urandom); hsub[t] = 1'($urandom);
         sw_valid = hv[t]; sw_a = ha[t]; sw_b = hb[t]; sw_ci = hci[t]; sw_sub = hsub[t];
         #1;
         n_vec++; if (sw_ir !== '1) begin n_bad++; $display("FAIL sweep_in_ready t=%0d: got %b expected all 1", t, sw_ir); end
         @(posedge clk); #1;
         for (int i = 0; i < NSW; i++) begin
            d  = t + 1 - (i % 4 + 1);
            ev = (d >= 0) ? hv[d] : 1'b0;
            n_vec++;
            if (sw_ov[i] !== ev) begin
               n_bad++; $display("FAIL sweep_valid w=%0d s=%0d t=%0d: got %b expected %b", sw_width(i), i % 4 + 1, t, sw_ov[i], ev);
            end else if (ev) begin
               e = ref_add(ha[d], hb[d], hci[d], hsub[d], sw_width(i));
               n_vec++;
               if (sw_sum[i] !== e.sum || sw_co[i] !== e.co || sw_ovf[i] !== e.ovf || sw_zero[i] !== e.zero) begin
                  n_bad++;
                  $display("FAIL sweep_data w=%0d s=%0d t=%0d: got %h/%b%b%b expected %h/%b%b%b", sw_width(i), i % 4 + 1, t,
                           sw_sum[i], sw_co[i], sw_ovf[i], sw_zero[i], e.sum, e.co, e.ovf, e.zero);
               end
            end
         end
      end
      sw_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_vector("wrap",     32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
      test_vector("ovf_pos",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      test_vector("sub_eq",   32'd5,         32'd5,         1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
      test_vector("sub_neg",  32'd3,         32'd5,         1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      test_vector("add_ci",   32'h0000_00FF, 32'h0000_0F00, 1'b1, 1'b0, 32'h0000_1000, 1'b0, 1'b0, 1'b0);
      test_vector("ovf_neg",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
      test_back_to_back();
      test_stall();
      test_reset_flight();
      test_random_handshake();
      test_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/cla_adder_pipe.md
CLA_ADDER_PIPE -- requirements
Module: cla_adder_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the operand width in bits: a multiple of 4 in the range 4..64.
REQ-002 The block SHALL have parameter STAGES, default 2, the number of register stages from input to output, in the range 1..4.
REQ-003 The block SHALL have these ports:
- clk, input, 1 bit: the single clock; all state updates on the rising edge.
- rst, input, 1 bit: asynchronous, active-high reset.
- in_valid, input, 1 bit: operand set offered.
- in_ready, output, 1 bit: the block accepts the offered operand set this cycle.
- a, input, WIDTH bits: operand A.
- b, input, WIDTH bits: operand B.
- ci, input, 1 bit: carry-in.
- sub, input, 1 bit: 1 = subtract (A - B), 0 = add.
- out_valid, output, 1 bit: a result is presented.
- out_ready, input, 1 bit: the consumer accepts the result.
- sum, output, WIDTH bits: the result.
- co, output, 1 bit: carry-out of the MSB.
- ovf, output, 1 bit: signed overflow.
- zero, output, 1 bit: sum is all zeros.

Function
REQ-004 The effective B SHALL be b XOR {WIDTH{sub}}, and the effective carry-in SHALL be ci OR sub.
REQ-005 {co, sum} SHALL equal A + effective B + effective carry-in, computed modulo 2^(WIDTH+1).
REQ-006 Carries SHALL be formed with a hierarchical lookahead:
- per-bit P = A XOR Beff and G = A AND Beff;
- 4-bit groups producing group Pg and Gg;
- successive 4-ary levels up to WIDTH.
REQ-007 Lookahead levels SHALL be distributed across the STAGES registers; bit-exact results SHALL be identical for every STAGES value.
REQ-008 A transfer in SHALL occur when in_valid and in_ready are both 1; a transfer out SHALL occur when out_valid and out_ready are both 1.
REQ-009 The global advance enable SHALL be adv = NOT out_valid OR out_ready, and in_ready SHALL equal adv.
REQ-010 When adv = 1, every stage register and its valid bit SHALL shift forward one stage, and stage 0 SHALL capture in_valid.
REQ-011 When adv = 0, all stage registers SHALL hold and no input SHALL be accepted.
REQ-012 Latency SHALL be exactly STAGES cycles from an input transfer to out_valid, absent stalls.
REQ-013 Throughput SHALL be one operation per cycle while out_ready stays 1.
REQ-014 Invalid stages (bubbles) SHALL advance like valid stages and SHALL NOT be collapsed.
REQ-015 sum, co, ovf and zero SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-016 When out_valid = 0, the values of sum, co, ovf and zero SHALL be don't-care.
REQ-017 ovf SHALL equal the carry into the MSB XOR co.
REQ-018 zero SHALL equal NOR(sum).
REQ-019 A simultaneous input transfer and output transfer in the same cycle SHALL be legal and SHALL lose no data.

Reset
REQ-020 While rst = 1, all stage valid bits SHALL clear asynchronously, so out_valid = 0 and in_ready = 1.
REQ-021 While rst = 1, sum, co, ovf and zero SHALL read 0.
REQ-022 rst asserted mid-operation SHALL discard all in-flight results; no result accepted before reset SHALL emerge after it.
REQ-023 The first input transfer SHALL be possible in the first clock edge after rst deasserts.

Configuration
REQ-024 Macro CLA_ADDER_PIPE_FLAGS_EN SHALL control the status flags.
- Defined: ovf and zero are computed and pipelined per REQ-017 and REQ-018.
- Undefined: ovf and zero are tied to 0, no flag registers exist, and sum/co behaviour is unchanged.

Verification
REQ-025 The bench SHALL cover these scenarios (WIDTH=32, STAGES=2, flags enabled unless noted):
- a=0xFFFFFFFF, b=0x00000001, ci=0, sub=0 -> after 2 cycles: sum=0x00000000, co=1, zero=1, ovf=0.
- a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, co=0, ovf=1; a=5, b=5, sub=1 -> sum=0, co=1, zero=1.
- 8 back-to-back transfers with out_ready=1 -> 8 results on 8 consecutive cycles, in order, in_ready constantly 1.
- out_ready=0 for 5 cycles with pipeline full -> in_ready=0, sum and out_valid held; out_ready=1 -> results drain in order, none lost or duplicated.
- rst pulsed with 2 results in flight -> out_valid=0 immediately, outputs 0, neither result appears after release.
- Macro undefined, a=0x7FFFFFFF, b=1 -> sum=0x80000000, ovf=0, zero=0; randomized sweep against a reference model for STAGES=1..4 and WIDTH=4/32/64.
